// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file.
//   NREAD combinational read ports, two clocked write ports (port 1 wins on
//   an address collision), optional same-cycle write-to-read bypass, and
//   register 0 hardwired to zero. After reset a one-entry-per-cycle clear
//   sweep zeroes the array; ready stays low until the sweep finishes.
// Ports:
//   clk                      rising-edge clock
//   reset                    synchronous active-high reset
//   ready                    high once the clear sweep has completed
//   regwrite0/wa0/wd0        write port 0 (enable, address, data)
//   regwrite1/wa1/wd1        write port 1 (enable, address, data), higher priority
//   ra  [NREAD*REGBITS-1:0]  packed read addresses, port k at [k*REGBITS +: REGBITS]
//   rd  [NREAD*WIDTH-1:0]    packed read data,      port k at [k*WIDTH +: WIDTH]
module regfile_mp #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REGBITS = 5,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     regwrite0,
  input  logic [REGBITS-1:0]       wa0,
  input  logic [WIDTH-1:0]         wd0,
  input  logic                     regwrite1,
  input  logic [REGBITS-1:0]       wa1,
  input  logic [WIDTH-1:0]         wd1,
  input  logic [NREAD*REGBITS-1:0] ra,
  output logic [NREAD*WIDTH-1:0]   rd
);

  localparam int unsigned DEPTH = 1 << REGBITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             r_state;
  logic [REGBITS-1:0] r_clr_cnt;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic w_we0;
  logic w_we1;

  // Writes to address 0 are dropped so entry 0 keeps its cleared value.
  assign w_we0 = regwrite0 && (wa0 != '0);
  assign w_we1 = regwrite1 && (wa1 != '0);

  assign ready = (r_state == ST_RUN);

  // Sweep control: restart from entry 0 on every reset, go live after N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + REGBITS'(1);
          if (r_clr_cnt == REGBITS'(DEPTH - 1)) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: r_state <= ST_RUN;
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  // Storage: sweep zeroes one entry per cycle; user writes only when live.
  // Port 1 is assigned last so it wins when both ports hit the same entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else begin
        if (w_we0) begin
          r_mem[wa0] <= wd0;
        end
        if (w_we1) begin
          r_mem[wa1] <= wd1;
        end
      end
    end
  end

  // Read ports: forced to zero while not ready or for address 0; bypass
  // priority mirrors write priority so forwarded data equals next stored data.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [REGBITS-1:0] w_a;
    logic [WIDTH-1:0]   w_d;

    assign w_a = ra[k*REGBITS +: REGBITS];

    always_comb begin
      w_d = r_mem[w_a];
      if (!ready || (w_a == '0)) begin
        w_d = '0;
      end else if ((BYPASS != 0) && regwrite1 && (wa1 == w_a)) begin
        w_d = wd1;
      end else if ((BYPASS != 0) && regwrite0 && (wa0 == w_a)) begin
        w_d = wd0;
      end
    end

    assign rd[k*WIDTH +: WIDTH] = w_d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default config with and without bypass driven by a
// shared stimulus, plus a narrow 4-read-port config.
module tb_regfile_mp;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 2;
  localparam int unsigned N   = 32;
  localparam int unsigned CAW = 3;
  localparam int unsigned CDW = 16;
  localparam int unsigned CNR = 4;
  localparam int unsigned CN  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-width stimulus, shared by dut_a (bypass) and dut_b (no bypass)
  logic             reset = 1'b1;
  logic             regwrite0 = 1'b0, regwrite1 = 1'b0;
  logic [AW-1:0]    wa0 = '0, wa1 = '0;
  logic [DW-1:0]    wd0 = '0, wd1 = '0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] rd_a, rd_b;
  logic             ready_a, ready_b;

  // narrow config stimulus
  logic               reset_c = 1'b1;
  logic               rw0c = 1'b0, rw1c = 1'b0;
  logic [CAW-1:0]     wa0c = '0, wa1c = '0;
  logic [CDW-1:0]     wd0c = '0, wd1c = '0;
  logic [CNR*CAW-1:0] ra_c = '0;
  logic [CNR*CDW-1:0] rd_c;
  logic               ready_c;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  regfile_mp #(.WIDTH(32), .REGBITS(5), .NREAD(2), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .ready(ready_a),
    .regwrite0(regwrite0), .wa0(wa0), .wd0(wd0),
    .regwrite1(regwrite1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_a));

  regfile_mp #(.WIDTH(32), .REGBITS(5), .NREAD(2), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b),
    .regwrite0(regwrite0), .wa0(wa0), .wd0(wd0),
    .regwrite1(regwrite1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd_b));

  regfile_mp #(.WIDTH(16), .REGBITS(3), .NREAD(4), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset_c), .ready(ready_c),
    .regwrite0(rw0c), .wa0(wa0c), .wd0(wd0c),
    .regwrite1(rw1c), .wa1(wa1c), .wd1(wd1c),
    .ra(ra_c), .rd(rd_c));

  // Behavioural model: entry contents plus count of non-reset edges since reset.
  logic [DW-1:0]  m_mem [N];
  int             m_cnt = 0;
  logic [CDW-1:0] c_mem [CN];
  int             c_cnt = 0;

  always @(posedge clk) begin
    if (reset) m_cnt = 0;
    else if (m_cnt < int'(N)) begin m_mem[m_cnt] = '0; m_cnt++; end
    else begin
      if (regwrite0 && wa0 != 0) m_mem[wa0] = wd0;
      if (regwrite1 && wa1 != 0) m_mem[wa1] = wd1;
    end
    if (reset_c) c_cnt = 0;
    else if (c_cnt < int'(CN)) begin c_mem[c_cnt] = '0; c_cnt++; end
    else begin
      if (rw0c && wa0c != 0) c_mem[wa0c] = wd0c;
      if (rw1c && wa1c != 0) c_mem[wa1c] = wd1c;
    end
  end

  // With bypass, a read returns what the entry will hold after this edge.
  function automatic logic [DW-1:0] exp_a(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] v;
    if (m_cnt < int'(N) || a == 0) return '0;
    v = m_mem[a];
    if (byp) begin
      if (regwrite0 && wa0 == a) v = wd0;
      if (regwrite1 && wa1 == a) v = wd1;
    end
    return v;
  endfunction

  function automatic logic [CDW-1:0] exp_c(input logic [CAW-1:0] a);
    logic [CDW-1:0] v;
    if (c_cnt < int'(CN) || a == 0) return '0;
    v = c_mem[a];
    if (rw0c && wa0c == a) v = wd0c;
    if (rw1c && wa1c == a) v = wd1c;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_a", 64'(ready_a), 64'(m_cnt >= int'(N)));
      check("ready_b", 64'(ready_b), 64'(m_cnt >= int'(N)));
      check("ready_c", 64'(ready_c), 64'(c_cnt >= int'(CN)));
      for (int k = 0; k < int'(NR); k++) begin
        check($sformatf("model rd_a port%0d", k), 64'(rd_a[k*DW +: DW]), 64'(exp_a(ra[k*AW +: AW], 1'b1)));
        check($sformatf("model rd_b port%0d", k), 64'(rd_b[k*DW +: DW]), 64'(exp_a(ra[k*AW +: AW], 1'b0)));
      end
      for (int k = 0; k < int'(CNR); k++) begin
        check($sformatf("model rd_c port%0d", k), 64'(rd_c[k*CDW +: CDW]), 64'(exp_c(ra_c[k*CAW +: CAW])));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    regwrite0 = e0; wa0 = a0; wd0 = d0;
    regwrite1 = e1; wa1 = a1; wd1 = d1;
  endtask

  task automatic edges_to_ready_a(output int n);
    n = 0;
    while (!ready_a && n < 200) begin tick(); n++; end
  endtask

  initial begin
    int n;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("reset ready_a", 64'(ready_a), 64'd0);
    check("reset rd_a", 64'(rd_a), 64'd0);

    // initial sweep
    tick();
    reset = 1'b0;
    edges_to_ready_a(n);
    check("sweep edges", 64'(n), 64'd32);

    // basic dual write, same edge
    wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9, 32'h12345678);
    ra = {5'd9, 5'd5};
    @(negedge clk);
    check("bypass r5 pre-edge", 64'(rd_a[31:0]), 64'hDEADBEEF);
    check("nobypass r5 pre-edge", 64'(rd_b[31:0]), 64'h0);
    tick();
    wr(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("r5 port0", 64'(rd_b[31:0]), 64'hDEADBEEF);
    check("r9 port1", 64'(rd_b[63:32]), 64'h12345678);
    tick();
    ra = {5'd5, 5'd5};
    @(negedge clk);
    check("r5 both ports", 64'(rd_a), {32'hDEADBEEF, 32'hDEADBEEF});

    // write to r0 is discarded
    tick();
    wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0);
    ra = {5'd0, 5'd0};
    @(negedge clk);
    check("r0 during write", 64'(rd_a), 64'h0);
    tick();
    wr(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("r0 after write", 64'(rd_b), 64'h0);

    // collision on r7: port 1 wins
    tick();
    wr(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h0000BBBB);
    ra = {5'd7, 5'd7};
    @(negedge clk);
    check("collision bypass", 64'(rd_a[31:0]), 64'h0000BBBB);
    check("collision old", 64'(rd_b[31:0]), 64'h0);
    tick();
    wr(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("collision stored", 64'(rd_b[63:32]), 64'h0000BBBB);

    // bypass on r3 through read port 1
    tick();
    wr(1'b0, '0, '0, 1'b1, 5'd3, 32'h11111111);
    tick();
    wr(1'b1, 5'd3, 32'hCAFEF00D, 1'b0, '0, '0);
    ra = {5'd3, 5'd9};
    @(negedge clk);
    check("bypass r3 port1", 64'(rd_a[63:32]), 64'hCAFEF00D);
    check("nobypass r3 old", 64'(rd_b[63:32]), 64'h11111111);
    tick();
    wr(1'b0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    check("nobypass r3 new", 64'(rd_b[63:32]), 64'hCAFEF00D);

    // reset, write attempt during sweep, reset again at sweep count 10
    tick();
    reset = 1'b1;
    ra = {5'd4, 5'd5};
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) wr(1'b1, 5'd4, 32'h55, 1'b0, '0, '0);
      else wr(1'b0, '0, '0, 1'b0, '0, '0);
      if (i == 5) begin
        @(negedge clk);
        check("read during sweep", 64'(rd_a), 64'h0);
      end
      tick();
    end
    wr(1'b0, '0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edges_to_ready_a(n);
    check("restarted sweep edges", 64'(n), 64'd32);
    for (int a = 0; a < int'(N); a++) begin
      ra = {AW'(a), AW'(a)};
      @(negedge clk);
      check($sformatf("cleared r%0d", a), 64'(rd_b), 64'h0);
      tick();
    end

    // narrow config: 8-entry sweep and four independent read ports
    reset_c = 1'b0;
    n = 0;
    while (!ready_c && n < 200) begin tick(); n++; end
    check("narrow sweep edges", 64'(n), 64'd8);
    rw0c = 1'b1; wa0c = 3'd1; wd0c = 16'h1111;
    rw1c = 1'b1; wa1c = 3'd2; wd1c = 16'h2222;
    tick();
    wa0c = 3'd3; wd0c = 16'h3333;
    wa1c = 3'd6; wd1c = 16'hABCD;
    tick();
    rw0c = 1'b0; rw1c = 1'b0;
    ra_c = {3'd6, 3'd3, 3'd2, 3'd1};
    @(negedge clk);
    check("narrow port0", 64'(rd_c[15:0]), 64'h1111);
    check("narrow port1", 64'(rd_c[31:16]), 64'h2222);
    check("narrow port2", 64'(rd_c[47:32]), 64'h3333);
    check("narrow port3", 64'(rd_c[63:48]), 64'hABCD);
    tick();
    ra_c = {3'd1, 3'd0, 3'd6, 3'd2};
    @(negedge clk);
    check("narrow permuted", 64'(rd_c), {16'h1111, 16'h0000, 16'hABCD, 16'h2222});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
